// File: rtl/apu_pkg.sv
// Shared APU definitions: register map, noise period table and length table.
// The tables are fixed-width lookups; voices resize the result to their own
// timer/length widths.
package apu_pkg;

  // Register offsets within a voice's 4-byte window
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_UNUSED = 2'd1,
    REG_PERIOD = 2'd2,
    REG_LENGTH = 2'd3
  } reg_addr_e;

  localparam int PERIOD_TABLE_W = 12;
  localparam int LEN_TABLE_W    = 8;

  // Noise timer reload values, indexed by the 4-bit period index
  function automatic logic [PERIOD_TABLE_W-1:0] period_lookup(input logic [3:0] pi);
    logic [PERIOD_TABLE_W-1:0] p;
    case (pi)
      4'd0:    p = 12'd4;
      4'd1:    p = 12'd8;
      4'd2:    p = 12'd16;
      4'd3:    p = 12'd32;
      4'd4:    p = 12'd64;
      4'd5:    p = 12'd96;
      4'd6:    p = 12'd128;
      4'd7:    p = 12'd160;
      4'd8:    p = 12'd202;
      4'd9:    p = 12'd254;
      4'd10:   p = 12'd380;
      4'd11:   p = 12'd508;
      4'd12:   p = 12'd762;
      4'd13:   p = 12'd1016;
      4'd14:   p = 12'd2034;
      default: p = 12'd4068;
    endcase
    return p;
  endfunction

  // Length counter load values, indexed by the 5-bit length index
  function automatic logic [LEN_TABLE_W-1:0] len_lookup(input logic [4:0] li);
    logic [LEN_TABLE_W-1:0] l;
    case (li)
      5'd0:    l = 8'd10;
      5'd1:    l = 8'd254;
      5'd2:    l = 8'd20;
      5'd3:    l = 8'd2;
      5'd4:    l = 8'd40;
      5'd5:    l = 8'd4;
      5'd6:    l = 8'd80;
      5'd7:    l = 8'd6;
      5'd8:    l = 8'd160;
      5'd9:    l = 8'd8;
      5'd10:   l = 8'd60;
      5'd11:   l = 8'd10;
      5'd12:   l = 8'd14;
      5'd13:   l = 8'd12;
      5'd14:   l = 8'd26;
      5'd15:   l = 8'd14;
      5'd16:   l = 8'd12;
      5'd17:   l = 8'd16;
      5'd18:   l = 8'd24;
      5'd19:   l = 8'd18;
      5'd20:   l = 8'd48;
      5'd21:   l = 8'd20;
      5'd22:   l = 8'd96;
      5'd23:   l = 8'd22;
      5'd24:   l = 8'd192;
      5'd25:   l = 8'd24;
      5'd26:   l = 8'd72;
      5'd27:   l = 8'd26;
      5'd28:   l = 8'd16;
      5'd29:   l = 8'd28;
      5'd30:   l = 8'd32;
      default: l = 8'd30;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/apu_envelope.sv
// APU envelope generator: start flag, divider and decay level with optional
// looping. Shared by the noise voice and, later, the pulse voices.
module apu_envelope
  import apu_pkg::*;
#(
  parameter int VOL_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             qtr_tick_i,
  input  logic             start_set_i,
  input  logic             loop_i,
  input  logic [VOL_W-1:0] n_i,
  output logic [VOL_W-1:0] decay_o
);

  logic             start_q, start_d;
  logic [VOL_W-1:0] div_q, div_d;
  logic [VOL_W-1:0] decay_q, decay_d;

  // Quarter-frame envelope step; a start request raised this cycle is seen by the next tick
  always_comb begin
    start_d = start_q;
    div_d   = div_q;
    decay_d = decay_q;
    if (qtr_tick_i) begin
      if (start_q) begin
        start_d = 1'b0;
        decay_d = '1;
        div_d   = n_i;
      end else if (div_q == '0) begin
        div_d = n_i;
        if (decay_q != '0) begin
          decay_d = decay_q - VOL_W'(1);
        end else if (loop_i) begin
          decay_d = '1;
        end
      end else begin
        div_d = div_q - VOL_W'(1);
      end
    end
    if (start_set_i) begin
      start_d = 1'b1;
    end
  end

  // Envelope state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      div_q   <= '0;
      decay_q <= '0;
    end else begin
      start_q <= start_d;
      div_q   <= div_d;
      decay_q <= decay_d;
    end
  end

  assign decay_o = decay_q;

endmodule

// File: rtl/noise_channel.sv
// NES-style noise voice: LFSR noise clocked by a table-driven period timer,
// envelope (apu_envelope), length counter and registered volume output.
// Optional build macro NOISE_DEBUG_EN exposes the live LFSR (lfsr_q) and the
// envelope decay level (env_q) as extra outputs.
module noise_channel
  import apu_pkg::*;
#(
  parameter int LFSR_W    = 15,
  parameter int TAP_LONG  = 1,
  parameter int TAP_SHORT = 6,
  parameter int PERIOD_W  = 12,
  parameter int LEN_W     = 8,
  parameter int VOL_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_tick,
  input  logic             qtr_tick,
  input  logic             half_tick,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             ch_enable,
  output logic [VOL_W-1:0] vol,
  output logic             active
`ifdef NOISE_DEBUG_EN
  ,
  output logic [LFSR_W-1:0] lfsr_q,
  output logic [VOL_W-1:0]  env_q
`endif
);

  logic                halt_q, halt_d;
  logic                const_q, const_d;
  logic [VOL_W-1:0]    n_q, n_d;
  logic                mode_q, mode_d;
  logic [3:0]          pi_q, pi_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [LFSR_W-1:0]   noise_q, noise_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic [VOL_W-1:0]    decay;
  logic                wr_ctrl, wr_period, wr_length;
  logic                fb;
  logic                unused_wr_bits;

  assign wr_ctrl   = wr_en && (wr_addr == REG_CTRL);
  assign wr_period = wr_en && (wr_addr == REG_PERIOD);
  assign wr_length = wr_en && (wr_addr == REG_LENGTH);

  // Data bits that no register field uses
  assign unused_wr_bits = ^{wr_data[7:6], wr_data[6:4], wr_data[2:0]};

  apu_envelope #(
    .VOL_W(VOL_W)
  ) u_envelope (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .qtr_tick_i  (qtr_tick),
    .start_set_i (wr_length),
    .loop_i      (halt_q),
    .n_i         (n_q),
    .decay_o     (decay)
  );

  // CPU-visible control fields latched from register writes
  always_comb begin
    halt_d  = halt_q;
    const_d = const_q;
    n_d     = n_q;
    mode_d  = mode_q;
    pi_d    = pi_q;
    if (wr_ctrl) begin
      halt_d  = wr_data[5];
      const_d = wr_data[4];
      n_d     = VOL_W'(wr_data[3:0]);
    end
    if (wr_period) begin
      mode_d = wr_data[7];
      pi_d   = wr_data[3:0];
    end
  end

  assign fb = noise_q[0] ^ (mode_q ? noise_q[TAP_SHORT] : noise_q[TAP_LONG]);

  // Period timer; the LFSR advances on the tick that finds the timer at zero
  always_comb begin
    timer_d = timer_q;
    noise_d = noise_q;
    if (timer_tick) begin
      if (timer_q == '0) begin
        timer_d = PERIOD_W'(period_lookup(pi_q));
        noise_d = {fb, noise_q[LFSR_W-1:1]};
      end else begin
        timer_d = timer_q - PERIOD_W'(1);
      end
    end
  end

  // Length counter: disable clears it, a length load beats a same-cycle half tick
  always_comb begin
    len_d = len_q;
    if (!ch_enable) begin
      len_d = '0;
    end else if (wr_length) begin
      len_d = LEN_W'(len_lookup(wr_data[7:3]));
    end else if (half_tick && !halt_q && (len_q != '0)) begin
      len_d = len_q - LEN_W'(1);
    end
  end

  // Output sample: silenced by LFSR bit 0 or an expired length counter
  always_comb begin
    vol_d = '0;
    if (!noise_q[0] && (len_q != '0)) begin
      vol_d = const_q ? n_q : decay;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q  <= 1'b0;
      const_q <= 1'b0;
      n_q     <= '0;
      mode_q  <= 1'b0;
      pi_q    <= '0;
      timer_q <= '0;
      noise_q <= LFSR_W'(1);
      len_q   <= '0;
      vol_q   <= '0;
    end else begin
      halt_q  <= halt_d;
      const_q <= const_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
      pi_q    <= pi_d;
      timer_q <= timer_d;
      noise_q <= noise_d;
      len_q   <= len_d;
      vol_q   <= vol_d;
    end
  end

  assign vol    = vol_q;
  assign active = (len_q != '0);

`ifdef NOISE_DEBUG_EN
  assign lfsr_q = noise_q;
  assign env_q  = decay;
`endif

endmodule

// File: tb/tb_noise_channel.sv
// Testbench for noise_channel: directed vector table, hand-written corner
// sequences and randomized traffic checked against a behavioural model.
module tb_noise_channel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       timer_tick = 1'b0;
  logic       qtr_tick = 1'b0;
  logic       half_tick = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       ch_enable = 1'b0;
  logic [3:0] vol;
  logic       active;
`ifdef NOISE_DEBUG_EN
  logic [14:0] lfsr_q;
  logic [3:0]  env_q;
`endif

  noise_channel dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .timer_tick (timer_tick),
    .qtr_tick   (qtr_tick),
    .half_tick  (half_tick),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ch_enable  (ch_enable),
    .vol        (vol),
    .active     (active)
`ifdef NOISE_DEBUG_EN
    ,
    .lfsr_q     (lfsr_q),
    .env_q      (env_q)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  bit modelCheck = 1'b0;

  int PERIOD_T [16] = '{4, 8, 16, 32, 64, 96, 128, 160, 202, 254, 380, 508, 762, 1016, 2034, 4068};
  int LEN_T [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                     12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  // Behavioural model: the LFSR steps once every (period+1) timer ticks
  logic [14:0] mLfsr;
  int  mTicksLeft, mPi, mN, mLen, mDecay, mDiv, mVol;
  bit  mMode, mHalt, mConst, mStart;

  task automatic modelReset();
    mLfsr = 15'd1; mTicksLeft = 1; mPi = 0; mN = 0; mLen = 0;
    mDecay = 0; mDiv = 0; mVol = 0; mMode = 0; mHalt = 0; mConst = 0; mStart = 0;
  endtask

  task automatic modelStep();
    int newVol;
    bit fb;
    newVol = (mLfsr[0] || mLen == 0) ? 0 : (mConst ? mN : mDecay);
    if (timer_tick) begin
      mTicksLeft--;
      if (mTicksLeft == 0) begin
        fb = mLfsr[0] ^ (mMode ? mLfsr[6] : mLfsr[1]);
        mLfsr = {fb, mLfsr[14:1]};
        mTicksLeft = PERIOD_T[mPi] + 1;
      end
    end
    if (qtr_tick) begin
      if (mStart) begin
        mStart = 0; mDecay = 15; mDiv = mN;
      end else if (mDiv == 0) begin
        mDiv = mN;
        if (mDecay > 0) mDecay--;
        else if (mHalt) mDecay = 15;
      end else begin
        mDiv--;
      end
    end
    if (!ch_enable) mLen = 0;
    else if (wr_en && wr_addr == 2'd3) mLen = LEN_T[wr_data[7:3]];
    else if (half_tick && !mHalt && mLen != 0) mLen--;
    if (wr_en) begin
      case (wr_addr)
        2'd0: begin mHalt = wr_data[5]; mConst = wr_data[4]; mN = int'(wr_data[3:0]); end
        2'd2: begin mMode = wr_data[7]; mPi = int'(wr_data[3:0]); end
        2'd3: mStart = 1;
        default: ;
      endcase
    end
    mVol = newVol;
  endtask

  task automatic checkOutput(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("model_vol", int'(vol), mVol);
    checkOutput("model_active", int'(active), (mLen != 0) ? 1 : 0);
`ifdef NOISE_DEBUG_EN
    checkOutput("model_lfsr", int'(lfsr_q), int'(mLfsr));
    checkOutput("model_env", int'(env_q), mDecay);
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, sample #1 later
  task automatic applyStimulus(input bit w, input bit [1:0] a, input bit [7:0] d,
                               input bit tt, input bit qt, input bit ht, input bit en);
    wr_en = w; wr_addr = a; wr_data = d;
    timer_tick = tt; qtr_tick = qt; half_tick = ht; ch_enable = en;
    @(posedge clk);
    modelStep();
    #1;
    if (modelCheck) compareModel();
  endtask

  task automatic idle(input bit en);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, en);
  endtask

  task automatic writeReg(input bit [1:0] a, input bit [7:0] d, input bit en);
    applyStimulus(1'b1, a, d, 1'b0, 1'b0, 1'b0, en);
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear without a clock edge
  task automatic doReset(input string name);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput({name, "_vol"}, int'(vol), 0);
    checkOutput({name, "_active"}, int'(active), 0);
`ifdef NOISE_DEBUG_EN
    checkOutput({name, "_lfsr"}, int'(lfsr_q), 1);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit       w;
    bit [1:0] a;
    bit [7:0] d;
    bit       tt, qt, ht, en;
    int       expVol;
    int       expActive;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int kExp;
    modelReset();

    vecs[0]  = '{0, 2'd0, 8'h00, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{1, 2'd0, 8'h1F, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{1, 2'd2, 8'h00, 0, 0, 0, 1, 0, 0};
    vecs[3]  = '{1, 2'd3, 8'h08, 0, 0, 0, 1, 0, 1};
    vecs[4]  = '{0, 2'd0, 8'h00, 0, 0, 0, 1, 0, 1};
    vecs[5]  = '{0, 2'd0, 8'h00, 1, 0, 0, 1, 0, 1};
    vecs[6]  = '{0, 2'd0, 8'h00, 0, 0, 0, 1, 15, 1};
    vecs[7]  = '{1, 2'd0, 8'h10, 0, 0, 0, 1, 15, 1};
    vecs[8]  = '{0, 2'd0, 8'h00, 0, 0, 0, 1, 0, 1};
    vecs[9]  = '{1, 2'd0, 8'h00, 0, 0, 0, 1, 0, 1};
    vecs[10] = '{0, 2'd0, 8'h00, 0, 0, 0, 1, 0, 1};
    vecs[11] = '{0, 2'd0, 8'h00, 0, 1, 0, 1, 0, 1};
    vecs[12] = '{0, 2'd0, 8'h00, 0, 0, 0, 1, 15, 1};
    vecs[13] = '{0, 2'd0, 8'h00, 0, 0, 0, 0, 15, 0};
    vecs[14] = '{0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0};
    vecs[15] = '{1, 2'd3, 8'h08, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{0, 2'd0, 8'h00, 0, 0, 0, 1, 0, 0};

    // Reset state before any clock
    #2;
    checkOutput("reset_vol", int'(vol), 0);
    checkOutput("reset_active", int'(active), 0);
`ifdef NOISE_DEBUG_EN
    checkOutput("reset_lfsr", int'(lfsr_q), 1);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].tt, vecs[i].qt, vecs[i].ht, vecs[i].en);
      checkOutput($sformatf("vec%0d_vol", i), int'(vol), vecs[i].expVol);
      checkOutput($sformatf("vec%0d_active", i), int'(active), vecs[i].expActive);
    end

    modelCheck = 1'b1;

    // Length countdown from 254 with halt clear, then frozen with halt set
    doReset("rst_len");
    writeReg(2'd0, 8'h0F, 1'b1);
    writeReg(2'd3, 8'h08, 1'b1);
    for (int i = 0; i < 253; i++) applyStimulus(0, 2'd0, 8'h00, 0, 0, 1, 1);
    checkOutput("len_253_active", int'(active), 1);
    applyStimulus(0, 2'd0, 8'h00, 0, 0, 1, 1);
    checkOutput("len_254_active", int'(active), 0);
    writeReg(2'd0, 8'h20, 1'b1);
    writeReg(2'd3, 8'h08, 1'b1);
    for (int i = 0; i < 300; i++) applyStimulus(0, 2'd0, 8'h00, 0, 0, 1, 1);
    checkOutput("len_halt_active", int'(active), 1);

    // Length load and half tick together: the load (li=3 -> 2) wins
    writeReg(2'd0, 8'h00, 1'b1);
    applyStimulus(1, 2'd3, 8'h18, 0, 0, 1, 1);
    applyStimulus(0, 2'd0, 8'h00, 0, 0, 1, 1);
    checkOutput("len_load_win_1", int'(active), 1);
    applyStimulus(0, 2'd0, 8'h00, 0, 0, 1, 1);
    checkOutput("len_load_win_0", int'(active), 0);

    // Envelope decay, n=3: 15 then one step down every 4 quarter ticks, holds at 0
    doReset("rst_env");
    applyStimulus(0, 2'd0, 8'h00, 1, 0, 0, 1);
    writeReg(2'd0, 8'h03, 1'b1);
    writeReg(2'd3, 8'h08, 1'b1);
    for (int k = 1; k <= 70; k++) begin
      applyStimulus(0, 2'd0, 8'h00, 0, 1, 0, 1);
      idle(1'b1);
      kExp = 15 - (k - 1) / 4;
      if (kExp < 0) kExp = 0;
      if (k % 10 == 1) checkOutput($sformatf("env_k%0d", k), int'(vol), kExp);
    end
    // Looping envelope wraps 0 -> 15
    writeReg(2'd0, 8'h23, 1'b1);
    writeReg(2'd3, 8'h08, 1'b1);
    for (int k = 1; k <= 70; k++) begin
      applyStimulus(0, 2'd0, 8'h00, 0, 1, 0, 1);
      idle(1'b1);
      kExp = ((15 - (k - 1) / 4) % 16 + 16) % 16;
      if (k % 4 == 1) checkOutput($sformatf("envloop_k%0d", k), int'(vol), kExp);
    end

    // Short mode from seed 1, two full 93-step periods
    doReset("rst_short");
    writeReg(2'd0, 8'h1F, 1'b1);
    writeReg(2'd2, 8'h80, 1'b1);
    writeReg(2'd3, 8'h08, 1'b1);
    for (int i = 0; i < 93 * 5 * 2 + 3; i++) applyStimulus(0, 2'd0, 8'h00, 1, 0, 0, 1);

    // Long mode, random traffic with a reset in the middle
    doReset("rst_rand");
    for (int i = 0; i < 3000; i++) begin
      bit w;
      bit [1:0] a;
      w = ($urandom_range(0, 7) == 0);
      a = 2'($urandom_range(0, 3));
      applyStimulus(w, a, 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) != 0));
      if (i == 1500) doReset("rst_mid");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
